// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down counter family.
// Direction/mode encodings and the default terminal value.
package counter_pkg;

  localparam logic CNT_UP   = 1'b1;
  localparam logic CNT_DN   = 1'b0;
  localparam logic CNT_WRAP = 1'b0;
  localparam logic CNT_SAT  = 1'b1;

  function automatic longint unsigned max_default(
    input int unsigned w
  );
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/counter_next.sv
// Next-state logic for the up/down counter.
// Pure combinational: load, bound handling and stepping.
module counter_next
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] MAXV  = '1
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up,
  input  logic             sat,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] next_q,
  output logic             bound_evt
);

  logic at_bound;
  logic step;

  assign at_bound  = (up == CNT_UP) ? (q == MAXV)
                                    : (q == '0);
  assign bound_evt = enable & ~load & at_bound;
  assign step      = enable & ~load & ~at_bound;

  always_comb begin
    next_q = q;
    unique case (1'b1)
      load: begin
        next_q = (d > MAXV) ? MAXV : d;
      end
      bound_evt: begin
        if (sat == CNT_WRAP) begin
          next_q = (up == CNT_UP) ? '0 : MAXV;
        end
      end
      step: begin
        next_q = (up == CNT_UP) ? q + 1'b1
                                : q - 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/counter_updown_mod.sv
// Parametrised up/down counter: registers plus terminal count.
// tc feeds the next stage's enable for cascading.
module counter_updown_mod
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter longint unsigned  MAX   = max_default(WIDTH)
) (
  input  logic             clock,
  input  logic             clear_b,
  input  logic             enable,
  input  logic             up,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  if (WIDTH < 1 || WIDTH > 63 || MAX == 0 ||
      MAX > max_default(WIDTH)) begin : g_bad_param
    $error("counter_updown_mod: illegal WIDTH/MAX");
  end

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX);

  logic [WIDTH-1:0] next_q;
  logic             bound_evt;

  counter_next #(
    .WIDTH (WIDTH),
    .MAXV  (MAXV)
  ) u_next (
    .q         (Q),
    .up        (up),
    .sat       (sat),
    .enable    (enable),
    .load      (load),
    .d         (d),
    .next_q    (next_q),
    .bound_evt (bound_evt)
  );

  // Set of ovf wins over a same-cycle ovf_clr.
  always_ff @(posedge clock or negedge clear_b) begin
    if (!clear_b) begin
      Q    <= '0;
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      Q    <= next_q;
      wrap <= bound_evt & (sat == CNT_WRAP);
      ovf  <= bound_evt | (ovf & ~ovf_clr);
    end
  end

  assign tc = enable & ((up & (Q == MAXV)) |
                        (~up & (Q == '0)));

endmodule

// File: tb/tb_counter_updown_mod.sv
// Scoreboard bench for counter_updown_mod: directed vectors,
// expected responses queued by stimulus, checked by a monitor.
module tb_counter_updown_mod;

  typedef struct {
    int         id;
    string      name;
    logic [7:0] q;
    logic       w;
    logic       o;
    logic       t;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic clock   = 1'b0;
  logic clear_b = 1'b0;
  logic probe   = 1'b0;

  logic       a_en = 0, a_up = 0, a_sat = 0, a_ld = 0, a_oc = 0;
  logic [7:0] a_d  = '0;
  logic [7:0] a_q;
  logic       a_tc, a_w, a_o;

  logic       b_en = 0, b_up = 0, b_sat = 0, b_ld = 0, b_oc = 0;
  logic [3:0] b_d  = '0;
  logic [3:0] b_q;
  logic       b_tc, b_w, b_o;

  logic       c_en = 0;
  logic [3:0] c0_q, c1_q;
  logic       c0_tc, c0_w, c0_o;
  logic       c1_tc, c1_w, c1_o;

  int dq[12]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  bit dw[12]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
  bit dt[12]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
  bit dov[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
  int sq[4]   = '{1, 0, 0, 0};
  bit so[4]   = '{0, 0, 1, 1};
  bit st[4]   = '{0, 1, 1, 1};

  always #5 clock = ~clock;

  counter_updown_mod #(.WIDTH(8)) u_a (
    .clock (clock), .clear_b (clear_b),
    .enable (a_en), .up (a_up), .sat (a_sat),
    .load (a_ld), .d (a_d), .ovf_clr (a_oc),
    .Q (a_q), .tc (a_tc), .wrap (a_w), .ovf (a_o)
  );

  counter_updown_mod #(.WIDTH(4), .MAX(9)) u_b (
    .clock (clock), .clear_b (clear_b),
    .enable (b_en), .up (b_up), .sat (b_sat),
    .load (b_ld), .d (b_d), .ovf_clr (b_oc),
    .Q (b_q), .tc (b_tc), .wrap (b_w), .ovf (b_o)
  );

  counter_updown_mod #(.WIDTH(4), .MAX(9)) u_c0 (
    .clock (clock), .clear_b (clear_b),
    .enable (c_en), .up (1'b1), .sat (1'b0),
    .load (1'b0), .d (4'd0), .ovf_clr (1'b0),
    .Q (c0_q), .tc (c0_tc), .wrap (c0_w), .ovf (c0_o)
  );

  counter_updown_mod #(.WIDTH(4), .MAX(9)) u_c1 (
    .clock (clock), .clear_b (clear_b),
    .enable (c0_tc), .up (1'b1), .sat (1'b0),
    .load (1'b0), .d (4'd0), .ovf_clr (1'b0),
    .Q (c1_q), .tc (c1_tc), .wrap (c1_w), .ovf (c1_o)
  );

  function automatic void push(input int id, input string nm,
                               input int q, input bit w,
                               input bit o, input bit t);
    exp_t e;
    e.id = id; e.name = nm; e.q = 8'(q);
    e.w = w; e.o = o; e.t = t;
    sb.push_back(e);
  endfunction

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic probe_now();
    probe = ~probe;
    #2;
  endtask

  // Monitor: drains the scoreboard after each edge or probe.
  initial begin : monitor
    exp_t       e;
    logic [7:0] q;
    logic       w, o, t;
    forever begin
      @(posedge clock or probe);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.id)
          0:       begin q = a_q;          w = a_w;  o = a_o;  t = a_tc;  end
          1:       begin q = {4'b0, b_q};  w = b_w;  o = b_o;  t = b_tc;  end
          2:       begin q = {4'b0, c0_q}; w = c0_w; o = c0_o; t = c0_tc; end
          default: begin q = {4'b0, c1_q}; w = c1_w; o = c1_o; t = c1_tc; end
        endcase
        checks++;
        if (q !== e.q || w !== e.w || o !== e.o || t !== e.t) begin
          errors++;
          $display("FAIL %s: got q=%0d wrap=%b ovf=%b tc=%b, want q=%0d wrap=%b ovf=%b tc=%b",
                   e.name, q, w, o, t, e.q, e.w, e.o, e.t);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    bit t0;
    b_en = 1; b_up = 0;
    #2;
    push(0, "rst_a", 0, 0, 0, 0);
    push(1, "rst_b_tc", 0, 0, 0, 1);
    push(2, "rst_c0", 0, 0, 0, 0);
    push(3, "rst_c1", 0, 0, 0, 0);
    probe_now();
    b_en = 0;
    @(negedge clock);
    clear_b = 1;

    // A: wrap down then up, then count to 0x37
    a_en = 1; a_up = 0;
    push(0, "a_dn_wrap", 255, 1, 1, 0);
    tick();
    a_up = 1;
    push(0, "a_up_wrap", 0, 1, 1, 0);
    tick();
    for (int i = 1; i <= 8'h37; i++) begin
      push(0, "a_count", i, 0, 1, 0);
      tick();
    end
    clear_b = 0;
    push(0, "a_rst_mid", 0, 0, 0, 0);
    probe_now();
    clear_b = 1;
    push(0, "a_resume", 1, 0, 0, 0);
    tick();
    a_en = 0;
    push(0, "a_hold", 1, 0, 0, 0);
    tick();

    // B: decade wrap up
    b_en = 1; b_up = 1; b_sat = 0;
    for (int i = 0; i < 12; i++) begin
      push(1, "b_decade", dq[i], dw[i], dov[i], dt[i]);
      tick();
    end

    // B: saturating down
    b_ld = 1; b_d = 4'd2; b_en = 0; b_oc = 1; b_sat = 1; b_up = 0;
    push(1, "b_load2", 2, 0, 0, 0);
    tick();
    b_ld = 0; b_oc = 0; b_en = 1;
    for (int i = 0; i < 4; i++) begin
      push(1, "b_sat_dn", sq[i], 0, so[i], st[i]);
      tick();
    end
    b_oc = 1; b_en = 0;
    push(1, "b_ovf_clr", 0, 0, 0, 0);
    tick();
    b_en = 1;
    push(1, "b_collide", 0, 0, 1, 1);
    tick();

    // B: load priority, clamp, wrap down
    b_ld = 1; b_up = 1; b_sat = 0; b_d = 4'd14;
    push(1, "b_clamp", 9, 0, 0, 1);
    tick();
    b_oc = 0; b_d = 4'd5;
    push(1, "b_load5", 5, 0, 0, 0);
    tick();
    b_d = 4'd0; b_en = 0;
    push(1, "b_load0", 0, 0, 0, 0);
    tick();
    b_ld = 0; b_en = 1; b_up = 0;
    push(1, "b_dn_wrap", 9, 1, 1, 0);
    tick();
    b_en = 0;
    push(1, "b_idle", 9, 0, 1, 0);
    tick();

    // Cascade of two decade stages, 100 edges
    c_en = 1;
    for (int i = 0; i < 100; i++) begin
      n  = i + 1;
      t0 = (n % 10) == 9;
      push(2, "c0_cnt", n % 10, (n % 10) == 0, n >= 10, t0);
      push(3, "c1_cnt", (n / 10) % 10, n == 100, n == 100,
           t0 && (((n / 10) % 10) == 9));
      tick();
    end
    c_en = 0;
    push(2, "c0_stop", 0, 0, 1, 0);
    push(3, "c1_stop", 0, 0, 1, 0);
    tick();

    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d left, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
